sram1rw128x12_adapter: RTL and testbench

Request/response front-end for one 128x12 single-port SRAM macro (active-low CSB/WEB/OEB, sampled on the macro clock edge, read data held on O until the next read). Sits directly upstream of the macro. Converts a valid/ready request stream into macro strobes and returns read data on a valid/ready response stream through a 2-entry buffer, so consumers may stall without losing reads. Optionally zero-fills the array after reset.

---
 rtl/sram1rw128x12_adapter_pkg.sv | 15 +
 rtl/sram1rw128x12_adapter_fifo.sv | 46 ++++
 rtl/sram1rw128x12_adapter.sv | 132 +++++++++++++
 tb/tb_sram1rw128x12_adapter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram1rw128x12_adapter_pkg.sv
// Shared constants and state type for the 128x12 single-port SRAM adapter.
// Optional array zero-fill after reset is enabled by SRAM1RW_ADAPTER_INIT_EN.
package sram1rw_adapter_pkg;

    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned DATA_W    = 12;
    localparam int unsigned DEPTH     = 128;
    localparam int unsigned RSP_DEPTH = 2;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

endpackage

// File: rtl/sram1rw128x12_adapter_fifo.sv
// Two-entry synchronous response FIFO with asynchronous active-high reset.
module sram_rsp_fifo2
    import sram1rw_adapter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [0:RSP_DEPTH-1];
    logic              rd_ptr;
    logic              wr_ptr;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sram1rw128x12_adapter.sv
// Valid/ready front-end for a 128x12 single-port SRAM macro with buffered read responses.
// Define SRAM1RW_ADAPTER_INIT_EN to zero-fill the array after every reset.
module sram1rw128x12_adapter
    import sram1rw_adapter_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_done,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    state_t            state;
    state_t            state_nxt;
    logic              pending;
    logic [1:0]        count;
    logic [DATA_W-1:0] fifo_head;
    logic              accept;
    logic              acc_rd;
    logic              acc_wr;
    logic              push;
    logic              pop;

`ifdef SRAM1RW_ADAPTER_INIT_EN
    logic [ADDR_W-1:0] init_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if ((state == INIT) && (&init_cnt)) state_nxt = RUN;
    end

    assign init_done = !reset && (state == RUN);
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = RUN;
    end

    assign init_done = !reset;
`endif

    // Reads are only admitted while the buffer plus the in-flight read leave room.
    always_comb begin
        req_ready = !reset && (state == RUN) &&
                    (req_write || (({1'b0, count} + {2'b00, pending}) < 3'd2));
        accept    = req_valid && req_ready;
        acc_rd    = accept && !req_write;
        acc_wr    = accept && req_write;
    end

    always_comb begin
        sram_csb = 1'b1;
        sram_web = 1'b1;
        sram_oeb = 1'b1;
        sram_a   = '0;
        sram_i   = '0;
        if (!reset) begin
`ifdef SRAM1RW_ADAPTER_INIT_EN
            if (state == INIT) begin
                sram_csb = 1'b0;
                sram_web = 1'b0;
                sram_a   = init_cnt;
            end else begin
                sram_a = req_addr;
            end
`else
            sram_a = req_addr;
`endif
            if (acc_wr) begin
                sram_csb = 1'b0;
                sram_web = 1'b0;
                sram_i   = req_wdata;
            end
            if (acc_rd) begin
                sram_csb = 1'b0;
                sram_oeb = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pending <= 1'b0;
        else       pending <= acc_rd;
    end

    // Macro data is live for one cycle only; park it unless bypassed straight out.
    always_comb begin
        pop       = (count != 2'd0) && rsp_ready;
        push      = pending && !((count == 2'd0) && rsp_ready);
        rsp_valid = (count != 2'd0) || pending;
        if (count != 2'd0) rsp_rdata = fifo_head;
        else if (pending)  rsp_rdata = sram_o;
        else               rsp_rdata = '0;
    end

    sram_rsp_fifo2 u_rsp_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (sram_o),
        .head  (fifo_head),
        .count (count)
    );

endmodule

// File: tb/tb_sram1rw128x12_adapter.sv
// Randomized bench for sram1rw128x12_adapter with a macro model and an outstanding-read reference.
// Follows SRAM1RW_ADAPTER_INIT_EN to pick the expected post-reset behaviour.
module tb_sram1rw128x12_adapter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [6:0]  req_addr;
    logic [11:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [11:0] rsp_rdata;
    logic        init_done;
    logic        sram_csb, sram_web, sram_oeb;
    logic [6:0]  sram_a;
    logic [11:0] sram_i, sram_o;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sram1rw128x12_adapter dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .sram_csb  (sram_csb),
        .sram_web  (sram_web),
        .sram_oeb  (sram_oeb),
        .sram_a    (sram_a),
        .sram_i    (sram_i),
        .sram_o    (sram_o)
    );

    // Single-port macro: write or read on the clock edge, O holds until the next read.
    logic [11:0] mac_mem [128];
    int          mac_writes = 0;
    always @(posedge clock) begin
        if (sram_csb == 1'b0) begin
            if (sram_web == 1'b0) begin
                mac_mem[sram_a] <= sram_i;
                mac_writes = mac_writes + 1;
            end else if (sram_oeb == 1'b0) begin
                sram_o <= mac_mem[sram_a];
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: contents as seen by requests, and the ordered list of reads owed.
    logic [11:0] ref_mem [128];
    logic [11:0] expq [$];
    logic [11:0] got [$];
    bit          mon_en = 0;
    bit          m_rd, m_wr, m_pop;
    logic [6:0]  m_addr;
    logic [11:0] m_wd;

    always @(negedge clock) begin
        if (mon_en && !reset) begin
            bit er, acc;
            er  = (req_write === 1'b1) || (expq.size() < 2);
            acc = (req_valid === 1'b1) && er;
            chk("req_ready", int'(req_ready), int'(er));
            chk("rsp_valid", int'(rsp_valid), int'(expq.size() > 0));
            if (expq.size() > 0) chk("rsp_rdata", int'(rsp_rdata), int'(expq[0]));
            chk("sram_csb", int'(sram_csb), int'(!acc));
            chk("sram_web", int'(sram_web), int'(!(acc && req_write)));
            chk("sram_oeb", int'(sram_oeb), int'(!(acc && !req_write)));
            if (acc) chk("sram_a", int'(sram_a), int'(req_addr));
            if (acc && req_write) chk("sram_i", int'(sram_i), int'(req_wdata));
            m_rd   = acc && !req_write;
            m_wr   = acc && req_write;
            m_pop  = (expq.size() > 0) && (rsp_ready === 1'b1);
            m_addr = req_addr;
            m_wd   = req_wdata;
        end
    end

    always @(posedge clock) begin
        if (mon_en && !reset) begin
            if (m_pop) begin
                got.push_back(expq[0]);
                void'(expq.pop_front());
            end
            if (m_wr) ref_mem[m_addr] = m_wd;
            if (m_rd) expq.push_back(ref_mem[m_addr]);
        end
        m_rd = 0; m_wr = 0; m_pop = 0;
    end

    bit toggle_en = 0;
    always @(posedge clock) begin
        if (toggle_en) begin
            #1 rsp_ready = ~rsp_ready;
        end
    end

    task automatic do_req(input bit w, input logic [6:0] a, input logic [11:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (req_ready === 1'b1) begin
                @(posedge clock); #1;
                req_valid = 1'b0;
                return;
            end
        end
        chk("req_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic wait_init();
        int n = 0;
        for (n = 0; n < 300; n++) begin
            @(negedge clock);
            if (init_done === 1'b1) break;
`ifdef SRAM1RW_ADAPTER_INIT_EN
            if (n == 0 || n == 127) begin
                chk("init_csb", int'(sram_csb), 0);
                chk("init_web", int'(sram_web), 0);
                chk("init_a", int'(sram_a), n);
                chk("init_i", int'(sram_i), 0);
            end
`endif
        end
`ifdef SRAM1RW_ADAPTER_INIT_EN
        chk("init_cycles", n, 128);
`else
        chk("init_cycles", n, 0);
`endif
        chk("ready_after_init", int'(req_ready), 1);
        @(posedge clock); #1;
        mon_en = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_rdata"}, int'(rsp_rdata), 0);
        chk({tag, "_strobes"}, int'({sram_csb, sram_web, sram_oeb}), 7);
        chk({tag, "_sram_a"}, int'(sram_a), 0);
        chk({tag, "_sram_i"}, int'(sram_i), 0);
        chk({tag, "_init_done"}, int'(init_done), 0);
    endtask

    task automatic reset_model();
        mon_en = 0;
        expq.delete();
`ifdef SRAM1RW_ADAPTER_INIT_EN
        for (int i = 0; i < 128; i++) ref_mem[i] = '0;
`endif
    endtask

    initial begin
        logic [11:0] lit [3];
        int w0;
        lit[0] = 12'h111; lit[1] = 12'h222; lit[2] = 12'h333;
        for (int i = 0; i < 128; i++) begin
            mac_mem[i] = 12'($urandom);
            ref_mem[i] = mac_mem[i];
        end
        reset = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 7'h33; req_wdata = 12'h5A5;
        rsp_ready = 1'b1;
        reset_model();
        #2;
        check_reset_outputs("rst");
        req_valid = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        wait_init();

`ifndef SRAM1RW_ADAPTER_INIT_EN
        w0 = mac_writes;
        repeat (10) @(posedge clock);
        chk("idle_writes", mac_writes - w0, 0);
`else
        foreach (lit[i]) begin
            do_req(1'b0, (i == 0) ? 7'd0 : (i == 1) ? 7'd64 : 7'd127, '0);
            @(negedge clock);
            chk("init_zero_rd", int'(rsp_rdata), 0);
            @(posedge clock); #1;
        end
`endif

        // Write-then-read same address, served by bypass the following cycle.
        do_req(1'b1, 7'h05, 12'hABC);
        do_req(1'b0, 7'h05, '0);
        @(negedge clock);
        chk("bypass_valid", int'(rsp_valid), 1);
        chk("bypass_data", int'(rsp_rdata), 12'hABC);
        @(posedge clock); #1;

        // Stall: two reads fill the buffer, the third read waits, a write still passes.
        do_req(1'b1, 7'h10, 12'h111);
        do_req(1'b1, 7'h11, 12'h222);
        do_req(1'b1, 7'h12, 12'h333);
        got.delete();
        rsp_ready = 1'b0;
        do_req(1'b0, 7'h10, '0);
        do_req(1'b0, 7'h11, '0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h12;
        @(negedge clock);
        chk("read_blocked", int'(req_ready), 0);
        @(posedge clock); #1;
        req_write = 1'b1; req_addr = 7'h20; req_wdata = 12'h444;
        @(negedge clock);
        chk("write_passes", int'(req_ready), 1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        do_req(1'b0, 7'h12, '0);
        repeat (4) @(posedge clock); #1;
        chk("stall_count", got.size(), 3);
        if (got.size() >= 3) foreach (lit[i]) chk("stall_order", int'(got[i]), int'(lit[i]));

        // Sixteen reads with rsp_ready toggling every cycle.
        got.delete();
        toggle_en = 1;
        for (int i = 0; i < 16; i++) do_req(1'b0, 7'($urandom_range(0, 31)), '0);
        toggle_en = 0;
        @(posedge clock); #2;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clock); #1;
        chk("toggle_count", got.size(), 16);

        // Random traffic over a narrow address window to exercise RAW hazards.
        for (int c = 0; c < 1500; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = $urandom_range(0, 1);
            req_addr  = 7'($urandom_range(0, 15));
            req_wdata = 12'($urandom);
            rsp_ready = ($urandom_range(0, 2) != 0);
            @(posedge clock); #1;
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (4) @(posedge clock); #1;

        // Reset with two reads outstanding.
        rsp_ready = 1'b0;
        do_req(1'b0, 7'h01, '0);
        do_req(1'b0, 7'h02, '0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'h03;
        #2;
        reset_model();
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clock); #2 reset = 1'b0;
        wait_init();
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("no_stale_rsp", int'(rsp_valid), 0);
        end
        do_req(1'b1, 7'h07, 12'h9C3);
        do_req(1'b0, 7'h07, '0);
        @(negedge clock);
        chk("post_rst_rd", int'(rsp_rdata), 12'h9C3);
        @(posedge clock); #1;
        mon_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
